// File: rtl/riot_pkg.sv
// Shared definitions for the 6532 RIOT model.
//   - I/O register offsets selected by ab[1:0] when ab[9]=1, ab[2]=0
//   - timer divider encoding selected by ab[1:0] on a timer write
//   - div_of(): divider ratio (1/8/64/1024) as an 11-bit value
//   - presc_of(): prescaler reload value (ratio - 1)
package riot_pkg;

  localparam logic [1:0] REG_ORA  = 2'd0;
  localparam logic [1:0] REG_DDRA = 2'd1;
  localparam logic [1:0] REG_ORB  = 2'd2;
  localparam logic [1:0] REG_DDRB = 2'd3;

  typedef enum logic [1:0] {
    DIV_1    = 2'd0,
    DIV_8    = 2'd1,
    DIV_64   = 2'd2,
    DIV_1024 = 2'd3
  } div_sel_e;

  function automatic logic [10:0] div_of(input div_sel_e sel);
    logic [10:0] ratio;
    ratio = 11'd1;
    case (sel)
      DIV_1:    ratio = 11'd1;
      DIV_8:    ratio = 11'd8;
      DIV_64:   ratio = 11'd64;
      DIV_1024: ratio = 11'd1024;
      default:  ratio = 11'd1;
    endcase
    return ratio;
  endfunction

  // Largest reload is 1023, so the prescaler only needs 10 bits.
  function automatic logic [9:0] presc_of(input div_sel_e sel);
    return 10'(div_of(sel) - 11'd1);
  endfunction

endpackage

// File: rtl/riot_ram.sv
// 128x8 RIOT scratch RAM.
//   eclk  : clock
//   we    : write enable (already qualified with phi2_en and select)
//   addr  : word address
//   wdata : write data
//   rdata : asynchronous read data
// Contents are deliberately not reset.
module riot_ram (
  input  logic       eclk,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [0:127];

  always_ff @(posedge eclk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riot_6532.sv
// 6532 RIOT: 128x8 RAM, two 8-bit I/O ports with direction registers and
// an 8-bit interval timer with selectable prescaler and interrupt.
//   eclk, ereset      : emulation clock, asynchronous active-low reset
//   phi2_en           : one-eclk strobe at the end of each CPU phi2 cycle
//   ab, rw, db_i      : CPU address, direction (1 = read), write data
//   db_o, db_oe       : read data and its drive enable
//   pa_i/pb_i         : port input pins
//   pa_o/pb_o         : output registers ORA/ORB
//   pa_oe/pb_oe       : direction registers DDRA/DDRB (1 = output)
//   irq_n             : active-low timer interrupt
module riot_6532
  import riot_pkg::*;
(
  input  logic        eclk,
  input  logic        ereset,
  input  logic        phi2_en,
  input  logic [12:0] ab,
  input  logic        rw,
  input  logic [7:0]  db_i,
  output logic [7:0]  db_o,
  output logic        db_oe,
  input  logic [7:0]  pa_i,
  input  logic [7:0]  pb_i,
  output logic [7:0]  pa_o,
  output logic [7:0]  pb_o,
  output logic [7:0]  pa_oe,
  output logic [7:0]  pb_oe,
  output logic        irq_n
);

  logic       sel;
  logic       bus_wr;
  logic       ram_we;
  logic       io_we;
  logic       tmr_we;
  logic       intim_rd;
  logic       underflow;
  logic [7:0] ram_rdata;

  logic [7:0] ora_reg, ddra_reg, orb_reg, ddrb_reg;
  logic [7:0] timer_reg;
  logic [9:0] presc_reg;
  logic       flag_reg;
  logic       ie_reg;
  logic       running_reg;
  div_sel_e   div_sel_reg;

  // Address lines not decoded by this part.
  logic unused_ab;
  assign unused_ab = &{1'b0, ab[11:10], ab[8]};

  assign sel      = !ab[12] && ab[7];
  assign bus_wr   = phi2_en && sel && !rw;
  assign ram_we   = bus_wr && !ab[9];
  assign io_we    = bus_wr && ab[9] && !ab[2];
  assign tmr_we   = bus_wr && ab[9] && ab[2] && ab[4];
  assign intim_rd = phi2_en && sel && rw && ab[9] && ab[2] && !ab[0];

  riot_ram u_ram (
    .eclk  (eclk),
    .we    (ram_we),
    .addr  (ab[6:0]),
    .wdata (db_i),
    .rdata (ram_rdata)
  );

  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) begin
      ora_reg  <= 8'h00;
      ddra_reg <= 8'h00;
      orb_reg  <= 8'h00;
      ddrb_reg <= 8'h00;
    end else if (io_we) begin
      case (ab[1:0])
        REG_ORA:  ora_reg  <= db_i;
        REG_DDRA: ddra_reg <= db_i;
        REG_ORB:  orb_reg  <= db_i;
        REG_DDRB: ddrb_reg <= db_i;
        default:  ;
      endcase
    end
  end

  // The timer only counts once it has been written since reset, so a reset
  // in the middle of a countdown leaves it parked at zero.
  assign underflow = phi2_en && running_reg && (presc_reg == 10'd0) &&
                     (timer_reg == 8'h00);

  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) begin
      timer_reg   <= 8'h00;
      presc_reg   <= 10'd0;
      flag_reg    <= 1'b0;
      ie_reg      <= 1'b0;
      running_reg <= 1'b0;
      div_sel_reg <= DIV_1024;
    end else if (tmr_we) begin
      // A write beats an underflow on the same edge.
      timer_reg   <= db_i;
      presc_reg   <= presc_of(div_sel_e'(ab[1:0]));
      div_sel_reg <= div_sel_e'(ab[1:0]);
      flag_reg    <= 1'b0;
      ie_reg      <= ab[3];
      running_reg <= 1'b1;
    end else if (phi2_en) begin
      if (running_reg) begin
        if (presc_reg != 10'd0) begin
          presc_reg <= presc_reg - 10'd1;
        end else begin
          timer_reg <= timer_reg - 8'd1;
          if (timer_reg == 8'h00) begin
            // After wrapping the timer counts down once per phi2.
            div_sel_reg <= DIV_1;
            presc_reg   <= 10'd0;
          end else begin
            presc_reg <= presc_of(div_sel_reg);
          end
        end
      end
      // Underflow wins over the clearing INTIM read.
      if (underflow) begin
        flag_reg <= 1'b1;
      end else if (intim_rd) begin
        flag_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    db_o = 8'h00;
    if (!ab[9]) begin
      db_o = ram_rdata;
    end else if (!ab[2]) begin
      case (ab[1:0])
        REG_ORA:  db_o = (ora_reg & ddra_reg) | (pa_i & ~ddra_reg);
        REG_DDRA: db_o = ddra_reg;
        REG_ORB:  db_o = (orb_reg & ddrb_reg) | (pb_i & ~ddrb_reg);
        REG_DDRB: db_o = ddrb_reg;
        default:  db_o = 8'h00;
      endcase
    end else if (!ab[0]) begin
      db_o = timer_reg;
    end else begin
      db_o = {flag_reg, 7'b0};
    end
  end

  assign db_oe = sel && rw;
  assign pa_o  = ora_reg;
  assign pb_o  = orb_reg;
  assign pa_oe = ddra_reg;
  assign pb_oe = ddrb_reg;
  assign irq_n = !(flag_reg && ie_reg);

endmodule

// File: tb/tb_riot_6532.sv
// Self-checking bench for riot_6532: directed scenarios followed by random
// bus traffic, all compared against a behavioural model in which the timer
// value is computed in closed form from the number of phi2 cycles since the
// last timer write.
module tb_riot_6532;

  logic        eclk;
  logic        ereset;
  logic        phi2_en;
  logic [12:0] ab;
  logic        rw;
  logic [7:0]  db_i;
  logic [7:0]  db_o;
  logic        db_oe;
  logic [7:0]  pa_i, pb_i;
  logic [7:0]  pa_o, pb_o, pa_oe, pb_oe;
  logic        irq_n;

  riot_6532 dut (
    .eclk    (eclk),
    .ereset  (ereset),
    .phi2_en (phi2_en),
    .ab      (ab),
    .rw      (rw),
    .db_i    (db_i),
    .db_o    (db_o),
    .db_oe   (db_oe),
    .pa_i    (pa_i),
    .pb_i    (pb_i),
    .pa_o    (pa_o),
    .pb_o    (pb_o),
    .pa_oe   (pa_oe),
    .pb_oe   (pb_oe),
    .irq_n   (irq_n)
  );

  initial begin
    eclk = 1'b0;
    forever #5 eclk = ~eclk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_ram [0:127];
  logic [7:0] m_ora, m_ddra, m_orb, m_ddrb;
  bit         m_ie, m_flag, m_armed;
  int         m_t, m_d, m_k;
  int         div_tab [4] = '{1, 8, 64, 1024};
  logic [7:0] pa_drv, pb_drv;

  function automatic void model_reset();
    m_ora = 0; m_ddra = 0; m_orb = 0; m_ddrb = 0;
    m_ie = 0; m_flag = 0; m_armed = 0;
    m_t = 0; m_d = 1024; m_k = 0;
  endfunction

  // Timer value k phi2 cycles after a write of T with ratio D: T - k/D until
  // the underflow at k = (T+1)*D, then 0xFF falling once per cycle, mod 256.
  function automatic logic [7:0] timer_val();
    int u;
    if (!m_armed) return 8'h00;
    u = (m_t + 1) * m_d;
    if (m_k < u) return 8'(m_t - m_k / m_d);
    return 8'(255 - ((m_k - u) % 256));
  endfunction

  function automatic logic [7:0] model_read(input logic [12:0] a);
    if (!a[9]) return m_ram[a[6:0]];
    if (!a[2]) begin
      case (a[1:0])
        2'd0: return (m_ora & m_ddra) | (pa_drv & ~m_ddra);
        2'd1: return m_ddra;
        2'd2: return (m_orb & m_ddrb) | (pb_drv & ~m_ddrb);
        default: return m_ddrb;
      endcase
    end
    if (!a[0]) return timer_val();
    return {m_flag, 7'b0};
  endfunction

  function automatic void model_edge(input logic [12:0] a, input logic r, input logic [7:0] d);
    bit s, wr, rd_intim, uf;
    int u;
    s        = !a[12] && a[7];
    wr       = s && !r;
    rd_intim = s && r && a[9] && a[2] && !a[0];
    if (wr && !a[9]) m_ram[a[6:0]] = d;
    if (wr && a[9] && !a[2]) begin
      case (a[1:0])
        2'd0: m_ora = d;
        2'd1: m_ddra = d;
        2'd2: m_orb = d;
        default: m_ddrb = d;
      endcase
    end
    if (wr && a[9] && a[2] && a[4]) begin
      m_t = int'(d); m_d = div_tab[a[1:0]]; m_k = 0;
      m_flag = 0; m_ie = a[3]; m_armed = 1;
    end else begin
      uf = 0;
      if (m_armed) begin
        m_k++;
        u  = (m_t + 1) * m_d;
        uf = (m_k >= u) && (((m_k - u) % 256) == 0);
      end
      if (uf) m_flag = 1;
      else if (rd_intim) m_flag = 0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_outputs(input string tag);
    check({tag, ".pa_o"},  pa_o,  m_ora);
    check({tag, ".pb_o"},  pb_o,  m_orb);
    check({tag, ".pa_oe"}, pa_oe, m_ddra);
    check({tag, ".pb_oe"}, pb_oe, m_ddrb);
    check({tag, ".irq_n"}, irq_n, !(m_flag && m_ie));
  endtask

  // One phi2 bus cycle: read data is sampled before the edge, registers after.
  task automatic bus(input string tag, input logic [12:0] a, input logic r, input logic [7:0] d);
    logic [7:0] exp_rd;
    bit s;
    s = !a[12] && a[7];
    @(negedge eclk);
    pa_i = pa_drv; pb_i = pb_drv;
    ab = a; rw = r; db_i = d; phi2_en = 1'b1;
    exp_rd = model_read(a);
    #1;
    check({tag, ".db_oe"}, db_oe, s && r);
    if (s && r) check({tag, ".db_o"}, db_o, exp_rd);
    $display("txn %0d %s ab=%03h rw=%0d wd=%02h rd=%02h oe=%0d irq_n=%0d",
             n_txn, tag, a, r, d, db_o, db_oe, irq_n);
    n_txn++;
    @(posedge eclk);
    #1;
    phi2_en = 1'b0;
    model_edge(a, r, d);
    check_outputs(tag);
  endtask

  // Clock cycles without phi2_en while the bus carries junk; nothing may change.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge eclk);
      ab = 13'($urandom); rw = 1'($urandom); db_i = 8'($urandom); phi2_en = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [12:0] a;
    logic        r;
    logic [7:0]  d;
    int          cat;

    ereset = 1'b0; phi2_en = 1'b0; ab = 13'h284; rw = 1'b1; db_i = 8'h00;
    pa_drv = 8'h00; pb_drv = 8'h00; pa_i = 8'h00; pb_i = 8'h00;
    model_reset();
    repeat (3) @(posedge eclk);
    @(negedge eclk);
    check_outputs("reset");
    check("reset.intim", db_o, 8'h00);
    ereset = 1'b1;

    // Fill RAM so every later read has a known value.
    for (int i = 0; i < 128; i++) bus("ram_init", 13'h080 | 13'(i), 1'b0, 8'($urandom));

    // RAM write/read and chip select.
    bus("ram_w", 13'h080, 1'b0, 8'hA5);
    bus("ram_r", 13'h080, 1'b1, 8'h00);
    bus("ram_a12", 13'h1080, 1'b1, 8'h00);

    // Port mixing of output register and input pins.
    pa_drv = 8'hC0;
    bus("ddra_w", 13'h281, 1'b0, 8'h0F);
    bus("ora_w",  13'h280, 1'b0, 8'h33);
    bus("pa_r",   13'h280, 1'b1, 8'h00);
    pb_drv = 8'h5A;
    bus("ddrb_w", 13'h283, 1'b0, 8'hF0);
    bus("orb_w",  13'h282, 1'b0, 8'hCC);
    bus("pb_r",   13'h282, 1'b1, 8'h00);

    // Divide-by-8 countdown through underflow.
    bus("tim8_w", 13'h29D, 1'b0, 8'h03);
    for (int j = 0; j < 34; j++) begin
      if (j == 32) bus("timint_r", 13'h285, 1'b1, 8'h00);
      else bus("intim_r", 13'h284, 1'b1, 8'h00);
      if (j % 5 == 2) idle(2);
    end

    // Underflow and INTIM read on the same phi2.
    bus("tim1_w", 13'h29C, 1'b0, 8'h02);
    for (int j = 0; j < 4; j++) bus("uf_rd", 13'h284, 1'b1, 8'h00);
    bus("timint_r", 13'h285, 1'b1, 8'h00);

    // Timer write on the same phi2 as an underflow.
    bus("tim1_w", 13'h29C, 1'b0, 8'h00);
    bus("tim_uf_w", 13'h29C, 1'b0, 8'h07);
    bus("intim_r", 13'h284, 1'b1, 8'h00);

    // Reset in the middle of a divide-by-1024 countdown.
    bus("ram_w", 13'h090, 1'b0, 8'h5A);
    bus("tim1k_w", 13'h29F, 1'b0, 8'h50);
    for (int j = 0; j < 40; j++) bus("intim_r", 13'h284, 1'b1, 8'h00);
    @(negedge eclk);
    #2 ereset = 1'b0;
    #1;
    model_reset();
    ab = 13'h284; rw = 1'b1; phi2_en = 1'b0;
    #1;
    check_outputs("mid_reset");
    check("mid_reset.intim", db_o, 8'h00);
    repeat (2) @(posedge eclk);
    @(negedge eclk);
    ereset = 1'b1;
    for (int j = 0; j < 20; j++) bus("post_rst_r", 13'h284, 1'b1, 8'h00);
    bus("ram_keep", 13'h090, 1'b1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      pa_drv = 8'($urandom); pb_drv = 8'($urandom);
      a = 13'($urandom); r = 1'($urandom); d = 8'($urandom);
      cat = $urandom_range(0, 9);
      if (cat != 9) begin
        a[12] = 1'b0; a[7] = 1'b1;
      end
      case (cat)
        0, 1: a[9] = 1'b0;
        2, 3: begin a[9] = 1'b1; a[2] = 1'b0; end
        4: begin
          a[9] = 1'b1; a[2] = 1'b1; a[4] = 1'b1; r = 1'b0;
          if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
          d = 8'($urandom_range(0, 12));
        end
        5, 6, 7: begin a[9] = 1'b1; a[2] = 1'b1; r = 1'b1; end
        8: begin a[9] = 1'b1; a[2] = 1'b1; end
        default: begin
          if ($urandom_range(0, 1) == 0) a[12] = 1'b1; else a[7] = 1'b0;
        end
      endcase
      bus("rand", a, r, d);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riot_6532.md
RIOT_6532 -- requirements
Module: riot_6532

Interface
REQ-001 The block SHALL have exactly one clock and one reset, listed first below.
REQ-002 eclk  in  1  emulation clock; all state SHALL change only on its rising edge.
REQ-003 ereset  in  1  reset, asynchronous, active-low.
REQ-004 phi2_en  in  1  one-eclk strobe marking the end of each CPU phi2 cycle; the bus SHALL be valid when it is high.
REQ-005 ab  in  13  CPU address bus.
REQ-006 rw  in  1  1 = read, 0 = write.
REQ-007 db_i  in  8  CPU write data.
REQ-008 db_o  out  8  read data.
REQ-009 db_oe  out  1  high when the block drives db_o.
REQ-010 pa_i/pb_i  in  8 each  port input pins.
REQ-011 pa_o/pb_o  out  8 each  port output registers ORA/ORB.
REQ-012 pa_oe/pb_oe  out  8 each  equal to DDRA/DDRB (1 = output).
REQ-013 irq_n  out  1  active-low timer interrupt.

Function
REQ-014 Chip select SHALL be sel = !ab[12] & ab[7].
REQ-015 ab[9]=0 SHALL select the RAM, 128x8, addressed by ab[6:0].
REQ-016 ab[9]=1, ab[2]=0 SHALL select I/O registers by ab[1:0]: 0=ORA/PA, 1=DDRA, 2=ORB/PB, 3=DDRB.
REQ-017 ab[9]=1, ab[2]=1, write, ab[4]=1 SHALL be a timer write:
- divider from ab[1:0]: 0=1, 1=8, 2=64, 3=1024
- interrupt enable ie <= ab[3]
REQ-018 ab[9]=1, ab[2]=1, read: ab[0]=0 SHALL return INTIM; ab[0]=1 SHALL return TIMINT = {flag,7'b0}.
REQ-019 Writes SHALL take effect only on eclk edges where phi2_en & sel & !rw.
REQ-020 db_o SHALL be combinational from ab and current state; db_oe = sel & rw.
REQ-021 Port read SHALL return (OR & DDR) | (p_i & ~DDR), per port.
REQ-022 Timer write SHALL load timer <= db_i and prescaler <= divider-1, set the active divider, and clear flag.
REQ-023 On every other phi2_en edge:
- prescaler != 0: prescaler decrements
- prescaler == 0: prescaler reloads to active divider-1 and timer decrements mod 256
REQ-024 Timer decrement 0x00 -> 0xFF SHALL set flag and force the active divider to 1 until the next timer write.
REQ-025 An INTIM read on phi2_en SHALL clear flag; an underflow on the same edge SHALL win (flag set).
REQ-026 A timer write on the same edge as an underflow SHALL win (flag cleared, new value loaded).
REQ-027 irq_n SHALL be !(flag & ie).
REQ-028 Without phi2_en, no state SHALL change.

Reset
REQ-029 While ereset=0 the following SHALL be zero: ORA, ORB, DDRA, DDRB, timer, prescaler, flag, ie.
REQ-030 While ereset=0, the active divider SHALL be 1024 and irq_n SHALL be 1.
REQ-031 RAM contents SHALL not be reset.
REQ-032 Reset asserted mid-countdown SHALL abort the count; counting SHALL resume only after a new timer write.

Structure
REQ-033 A shared package riot_pkg SHALL hold:
- register offsets
- divider encoding
- function div_of(sel) returning 1/8/64/1024 as an 11-bit value
REQ-034 RAM SHALL be the sub-module riot_ram (128x8, asynchronous read, synchronous write enable).
REQ-035 Timer, prescaler and flag SHALL be one always block; no derived clocks.

Verification
REQ-036 Write 0xA5 to 0x080, read 0x080 -> db_o=0xA5, db_oe=1; read 0x1080 (A12=1) -> db_oe=0.
REQ-037 Ports: DDRA=0x0F, ORA=0x33, pa_i=0xC0 -> read 0x280 = 0xC3; pa_oe=0x0F.
REQ-038 Write 0x03 to 0x29D (div 8, ie=1); check the timer sequence:
- INTIM reads 3 for 8 phi2_en
- then 2, 1, 0, each for 8 phi2_en
- then 0xFF with flag=1 and irq_n=0
- then 0xFE one phi2_en later (divide by 1)
REQ-039 Underflow and INTIM read on the same phi2_en -> flag=1; a following INTIM read -> flag=0, irq_n=1.
REQ-040 Assert ereset mid-count (divider 1024) -> timer=0, irq_n=1, all port registers 0; after release with no write, INTIM stays 0.
